cdma_status_poller: RTL and testbench

- Downstream companion of the CDMA register-programming stage.
- On that stage's `dma_done` pulse (length register written, CDMA transfer launched), polls the AXI CDMA status register (SR, offset 0x04) over the AXI-lite AR/R channels until the CDMA reports Idle or an error.
- Gives the core one completion pulse plus a sticky error code, so the OS loader and DMA users can stall on `xfer_busy`.

---
 rtl/cdma_status_poller_pkg.sv | 70 +++++++
 rtl/axil_read_single.sv | 68 ++++++
 rtl/cdma_status_poller.sv | 151 +++++++++++++++
 tb/tb_cdma_status_poller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdma_status_poller_pkg.sv
// Shared definitions for the CDMA status poller and its sibling programming stage.
//
// Contents:
//   poll_state_e     - poller FSM state encoding
//   Cdma*Offset      - AXI CDMA register offsets (AXI-lite byte addresses, 10 bits)
//   Sr*Bit / masks   - CDMA status register (SR) bit positions
//   err_code_e       - completion error codes reported on err_code
//   classify_status  - decides whether a polled SR word ends the transfer, and how
package cdma_status_poller_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGap,
        StAr,
        StR,
        StFin
    } poll_state_e;

    // CDMA register map (shared with the programming stage)
    localparam logic [9:0] CdmaSrOffset  = 10'h004;
    localparam logic [9:0] CdmaSaOffset  = 10'h018;
    localparam logic [9:0] CdmaDaOffset  = 10'h020;
    localparam logic [9:0] CdmaBttOffset = 10'h028;

    // SR bit positions
    localparam int unsigned SrIdleBit   = 1;
    localparam int unsigned SrIntErrBit = 4;
    localparam int unsigned SrSlvErrBit = 5;
    localparam int unsigned SrDecErrBit = 6;

    localparam logic [31:0] SrErrMask = (32'd1 << SrIntErrBit) |
                                        (32'd1 << SrSlvErrBit) |
                                        (32'd1 << SrDecErrBit);

    typedef enum logic [1:0] {
        ErrNone    = 2'b00,
        ErrResp    = 2'b01,
        ErrSr      = 2'b10,
        ErrTimeout = 2'b11
    } err_code_e;

    typedef struct packed {
        logic      finish;
        err_code_e code;
    } verdict_t;

    // Priority: bad response, SR error bits, Idle, poll budget exhausted.
    function automatic verdict_t classify_status(input logic [1:0]  resp,
                                                 input logic [31:0] sr,
                                                 input logic [31:0] err_mask,
                                                 input logic [31:0] idle_mask,
                                                 input logic        last_poll);
        verdict_t v;
        v.finish = 1'b1;
        v.code   = ErrNone;
        if (resp != 2'b00) begin
            v.code = ErrResp;
        end else if ((sr & err_mask) != '0) begin
            v.code = ErrSr;
        end else if ((sr & idle_mask) != '0) begin
            v.code = ErrNone;
        end else if (last_poll) begin
            v.code = ErrTimeout;
        end else begin
            v.finish = 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/axil_read_single.sv
// One-shot AXI-lite read master: issues a single AR beat, accepts the R beat,
// and presents the returned data/response with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   start              - begin a read of addr (ignored while busy)
//   addr               - read address
//   busy               - a read is outstanding (AR or R phase)
//   data, resp         - captured R beat, valid from the done pulse until the next read
//   done               - one-cycle pulse, the cycle after the R handshake
//   araddr, arvalid,
//   arready            - AXI-lite AR channel
//   rdata, rresp,
//   rvalid, rready     - AXI-lite R channel
module axil_read_single #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] addr,
    output logic          busy,
    output logic [DW-1:0] data,
    output logic [1:0]    resp,
    output logic          done,
    output logic [AW-1:0] araddr,
    output logic          arvalid,
    input  logic          arready,
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    rresp,
    input  logic          rvalid,
    output logic          rready
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr  <= '0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            data    <= '0;
            resp    <= 2'b00;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (arvalid) begin
                // arvalid/araddr held until the slave takes the address
                if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                end
            end else if (rready) begin
                if (rvalid) begin
                    rready <= 1'b0;
                    data   <= rdata;
                    resp   <= rresp;
                    done   <= 1'b1;
                end
            end else if (start) begin
                arvalid <= 1'b1;
                araddr  <= addr;
            end
        end
    end

    assign busy = arvalid | rready;

endmodule

// File: rtl/cdma_status_poller.sv
// Polls the AXI CDMA status register after the programming stage launches a
// transfer, and reports a single completion pulse plus a sticky error code.
//
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   dma_done                  - start pulse from the CDMA programming stage (IDLE only)
//   araddr, arvalid, arready  - AXI-lite AR channel to the CDMA
//   rdata, rresp, rvalid,
//   rready                    - AXI-lite R channel from the CDMA
//   xfer_busy                 - polling in progress
//   xfer_done                 - one-cycle completion pulse (success or failure)
//   xfer_err, err_code        - sticky result, cleared by the next accepted start
//   last_status               - last SR word received
module cdma_status_poller
    import cdma_status_poller_pkg::*;
#(
    parameter logic [9:0]  SR_ADDR   = CdmaSrOffset,
    parameter int unsigned POLL_GAP  = 8,
    parameter int unsigned MAX_POLLS = 1024,
    parameter int unsigned IDLE_BIT  = SrIdleBit,
    parameter logic [31:0] ERR_MASK  = SrErrMask
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_done,
    input  logic        arready,
    output logic [9:0]  araddr,
    output logic        arvalid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic        xfer_busy,
    output logic        xfer_done,
    output logic        xfer_err,
    output logic [1:0]  err_code,
    output logic [31:0] last_status
);

    localparam int unsigned GapW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int unsigned PollW = $clog2(MAX_POLLS + 1);

    localparam logic [GapW-1:0]  GapLoad   = GapW'(POLL_GAP - 1);
    localparam logic [PollW-1:0] MaxPollsC = PollW'(MAX_POLLS);
    localparam logic [31:0]      IdleMask  = 32'd1 << IDLE_BIT;

    poll_state_e      state;
    logic [GapW-1:0]  gap_cnt;
    logic [PollW-1:0] poll_cnt;

    logic        rd_start;
    logic        rd_busy;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_done;
    verdict_t    verdict;

    // Launch the read on the last gap cycle so arvalid rises as the FSM enters AR.
    assign rd_start = (state == StGap) && (gap_cnt == '0) && !rd_busy;

    assign verdict = classify_status(rd_resp, rd_data, ERR_MASK, IdleMask,
                                     poll_cnt == MaxPollsC);

    axil_read_single #(
        .AW (10),
        .DW (32)
    ) u_rd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (rd_start),
        .addr    (SR_ADDR),
        .busy    (rd_busy),
        .data    (rd_data),
        .resp    (rd_resp),
        .done    (rd_done),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            gap_cnt     <= '0;
            poll_cnt    <= '0;
            xfer_busy   <= 1'b0;
            xfer_done   <= 1'b0;
            xfer_err    <= 1'b0;
            err_code    <= ErrNone;
            last_status <= '0;
        end else begin
            xfer_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (dma_done) begin
                        state     <= StGap;
                        gap_cnt   <= GapLoad;
                        poll_cnt  <= '0;
                        xfer_err  <= 1'b0;
                        err_code  <= ErrNone;
                        xfer_busy <= 1'b1;
                    end
                end
                StGap: begin
                    if (gap_cnt == '0) begin
                        if (!rd_busy) begin
                            state <= StAr;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GapW'(1);
                    end
                end
                StAr: begin
                    if (arvalid && arready) begin
                        state <= StR;
                        // Saturating: the timeout compare must never see a wrapped count.
                        if (poll_cnt != MaxPollsC) begin
                            poll_cnt <= poll_cnt + PollW'(1);
                        end
                    end
                end
                StR: begin
                    if (rd_done) begin
                        last_status <= rd_data;
                        if (verdict.finish) begin
                            state     <= StFin;
                            xfer_done <= 1'b1;
                            xfer_busy <= 1'b0;
                            err_code  <= verdict.code;
                            xfer_err  <= (verdict.code != ErrNone);
                        end else begin
                            state   <= StGap;
                            gap_cnt <= GapLoad;
                        end
                    end
                end
                StFin: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdma_status_poller.sv
module tb_cdma_status_poller;

    logic        clk;
    logic        rst_n;
    logic        dma_done;
    logic        arready;
    logic [9:0]  araddr;
    logic        arvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        xfer_busy;
    logic        xfer_done;
    logic        xfer_err;
    logic [1:0]  err_code;
    logic [31:0] last_status;

    cdma_status_poller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dma_done    (dma_done),
        .arready     (arready),
        .araddr      (araddr),
        .arvalid     (arvalid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rvalid      (rvalid),
        .rready      (rready),
        .xfer_busy   (xfer_busy),
        .xfer_done   (xfer_done),
        .xfer_err    (xfer_err),
        .err_code    (err_code),
        .last_status (last_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  code;
        logic [31:0] status;
        int          reads;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] sr_q[$];
    logic [1:0]  resp_q[$];
    logic [31:0] sr_default;
    int          ar_delay;
    int          r_delay;
    int          n_ar;
    int          n_done;
    int          viol;
    int          cyc;
    int          ar_cyc[$];
    logic [9:0]  last_ar_addr;
    int          n_pass;
    int          n_checks;
    int          ar_base;
    int          done_base;
    longint      t_start;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // AXI-lite slave model: all events handled on the falling edge. Handshakes are
    // decided by values held across the rising edge, recorded right after driving.
    initial begin : slave
        logic       ar_hs_nx, r_hs_nx, ar_pend, r_pend, r_out;
        logic [9:0] addr_nx;
        int         ar_cnt, r_cnt;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        ar_hs_nx = 1'b0; r_hs_nx = 1'b0; ar_pend = 1'b0; r_pend = 1'b0; r_out = 1'b0;
        addr_nx = '0; ar_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                arready = 1'b0; rvalid = 1'b0; r_out = 1'b0; ar_cnt = 0;
                ar_hs_nx = 1'b0; r_hs_nx = 1'b0; ar_pend = 1'b0; r_pend = 1'b0;
            end else begin
                if (ar_pend && !(arvalid === 1'b1 && araddr === addr_nx)) viol++;
                if (r_pend && rready !== 1'b1) viol++;
                if (xfer_done === 1'b1) n_done++;
                if (ar_hs_nx) begin
                    n_ar++;
                    ar_cyc.push_back(cyc);
                    last_ar_addr = addr_nx;
                    arready = 1'b0; ar_cnt = 0; r_out = 1'b1; r_cnt = r_delay;
                end else if (arvalid && !arready) begin
                    if (ar_cnt >= ar_delay) arready = 1'b1;
                    else ar_cnt++;
                end
                if (r_hs_nx) begin
                    rvalid = 1'b0; r_out = 1'b0;
                end else if (r_out && !rvalid) begin
                    if (r_cnt == 0) begin
                        rvalid = 1'b1;
                        rdata  = (sr_q.size() > 0) ? sr_q.pop_front() : sr_default;
                        rresp  = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
                    end else begin
                        r_cnt--;
                    end
                end
                ar_hs_nx = arvalid && arready;
                r_hs_nx  = rvalid && rready;
                addr_nx  = araddr;
                ar_pend  = arvalid && !arready;
                r_pend   = rready && !rvalid;
            end
        end
    end

    task automatic push_exp(input logic [1:0] code, input logic [31:0] status, input int reads);
        exp_t e;
        e.code = code; e.status = status; e.reads = reads; e.err = (code != 2'b00);
        sb_q.push_back(e);
    endtask

    // Leaves the bench at the falling edge of the first cycle after dma_done.
    task automatic start_xfer();
        @(negedge clk);
        dma_done  = 1'b1;
        t_start   = $time;
        ar_base   = n_ar;
        done_base = n_done;
        @(negedge clk);
        dma_done  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        exp_t e;
        int   guard;
        int   lat;
        guard = 0;
        check_eq({tag, "_busy_during"}, {31'd0, xfer_busy}, 32'd1);
        while (xfer_done !== 1'b1 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        lat = int'(($time - t_start) / 10);
        if (guard >= 20000) begin
            check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            if (sb_q.size() == 0) begin
                check_eq({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_eq({tag, "_busy_at_done"}, {31'd0, xfer_busy}, 32'd0);
                check_eq({tag, "_xfer_err"}, {31'd0, xfer_err}, {31'd0, e.err});
                check_eq({tag, "_err_code"}, {30'd0, err_code}, {30'd0, e.code});
                check_eq({tag, "_last_status"}, last_status, e.status);
                check_eq({tag, "_reads"}, n_ar - ar_base, e.reads);
                if (exp_lat > 0) check_eq({tag, "_latency"}, lat, exp_lat);
            end
        end
    endtask

    task automatic check_single_done(input string tag);
        repeat (6) @(negedge clk);
        check_eq({tag, "_done_pulses"}, n_done - done_base, 32'd1);
    endtask

    initial begin : main
        int min_gap;
        int guard;
        n_pass = 0; n_checks = 0; n_ar = 0; n_done = 0; viol = 0; cyc = 0;
        last_ar_addr = '0; sr_default = 32'h2; ar_delay = 0; r_delay = 0;
        rst_n = 1'b0; dma_done = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_araddr", {22'd0, araddr}, 32'd0);
        check_eq("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check_eq("rst_rready", {31'd0, rready}, 32'd0);
        check_eq("rst_busy", {31'd0, xfer_busy}, 32'd0);
        check_eq("rst_done", {31'd0, xfer_done}, 32'd0);
        check_eq("rst_err", {31'd0, xfer_err}, 32'd0);
        check_eq("rst_code", {30'd0, err_code}, 32'd0);
        check_eq("rst_status", last_status, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("idle_no_ar", n_ar, 32'd0);

        // Already idle on the first read
        push_exp(2'b00, 32'h2, 1);
        start_xfer();
        wait_done("t1", 12);
        check_eq("t1_araddr", {22'd0, last_ar_addr}, 32'h4);
        check_single_done("t1");

        // Three busy reads, then idle
        sr_q = '{32'h0, 32'h0, 32'h0};
        ar_cyc.delete();
        push_exp(2'b00, 32'h2, 4);
        start_xfer();
        wait_done("t2", -1);
        min_gap = 1000000;
        for (int i = 1; i < ar_cyc.size(); i++)
            if (ar_cyc[i] - ar_cyc[i-1] < min_gap) min_gap = ar_cyc[i] - ar_cyc[i-1];
        check_eq("t2_spacing_ge_gap", {31'd0, min_gap >= 8}, 32'd1);
        check_single_done("t2");

        // Slave error on the second read, then a fresh start clears the error
        sr_q = '{32'h0, 32'h20};
        push_exp(2'b10, 32'h20, 2);
        start_xfer();
        wait_done("t3", -1);
        push_exp(2'b00, 32'h2, 1);
        start_xfer();
        check_eq("t3_err_cleared", {31'd0, xfer_err}, 32'd0);
        check_eq("t3_code_cleared", {30'd0, err_code}, 32'd0);
        wait_done("t3b", 12);

        // Bad response wins over Idle
        resp_q = '{2'b10};
        push_exp(2'b01, 32'h2, 1);
        start_xfer();
        wait_done("t4", 12);

        // Never idle: full poll budget, then timeout
        sr_default = 32'h0;
        push_exp(2'b11, 32'h0, 1024);
        start_xfer();
        wait_done("t5", -1);
        sr_default = 32'h2;

        // Stalled AR and R with a stray dma_done mid-poll
        ar_delay = 20; r_delay = 5; viol = 0;
        push_exp(2'b00, 32'h2, 1);
        start_xfer();
        repeat (14) @(negedge clk);
        check_eq("t6_arvalid_stall", {31'd0, arvalid}, 32'd1);
        dma_done = 1'b1;
        @(negedge clk);
        dma_done = 1'b0;
        wait_done("t6", 37);
        check_single_done("t6");
        check_eq("t6_handshake_stable", viol, 32'd0);

        // Reset while arvalid is high
        start_xfer();
        guard = 0;
        while (arvalid !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("t7_arvalid_before_rst", {31'd0, arvalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t7_rst_arvalid", {31'd0, arvalid}, 32'd0);
        check_eq("t7_rst_rready", {31'd0, rready}, 32'd0);
        check_eq("t7_rst_busy", {31'd0, xfer_busy}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        ar_base = n_ar;
        repeat (30) @(negedge clk);
        check_eq("t7_idle_no_ar", n_ar - ar_base, 32'd0);
        check_eq("t7_idle_busy", {31'd0, xfer_busy}, 32'd0);
        check_eq("t7_idle_no_done", n_done - done_base, 32'd0);
        ar_delay = 0; r_delay = 0;
        push_exp(2'b00, 32'h2, 1);
        start_xfer();
        wait_done("t7_after", 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
